// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared encodings for the multicycle controller.
//   - FSM state codes (legacy 4-bit constants)
//   - ALUControl codes, data-processing cmd codes
//   - ResultSrc / ALUSrcA / ALUSrcB / ImmSrc encodings
//   - ARM condition codes and the condition-check helper
//   - ctrl_t: raw per-state controls produced by the main FSM
package mc_control_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_CMP = 4'b0100;
  localparam logic [3:0] ALU_TEQ = 4'b0110;
  localparam logic [3:0] ALU_TST = 4'b0111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_RD1 = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       nextpc;
    logic       branch;
    logic       regw;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic       aluop;
    logic       decode;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
  } ctrl_t;

  // flags = {N,Z,C,V}; the unconditional-never encoding 1111 evaluates false.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n ~^ v;
      COND_LT: return n ^ v;
      COND_GT: return ~z & (n ~^ v);
      COND_LE: return z | (n ^ v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_mainfsm.sv
// mc_control_mainfsm: state register, next-state logic and raw per-state
// controls of the multicycle controller.
//   clk, reset (sync, active low)   : clock / reset
//   op, funct                        : instruction fields steering the sequence
//   nextpc..decode                   : raw enables (before condition gating)
//   resultsrc, alusrca, alusrcb      : datapath selects
module mc_control_mainfsm
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       nextpc,
  output logic       branch,
  output logic       regw,
  output logic       memw,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       aluop,
  output logic       decode,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb
);

  logic [3:0] state, nxt, cur;
  ctrl_t      c;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  nxt = S_MEMADR;
          OP_DP:   nxt = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   nxt = S_BRANCH;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXECR,
      S_EXECI:  nxt = S_ALUWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // While reset is held the selects present their FETCH values so the
  // datapath sees a stable, harmless configuration.
  assign cur = reset ? state : S_FETCH;

  always_comb begin
    c = '0;
    case (cur)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALU;
      end
      S_DECODE: begin
        c.decode    = 1'b1;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALU;
      end
      S_MEMADR: c.alusrcb = SRCB_IMM;
      S_MEMRD:  c.adrsrc  = 1'b1;
      S_MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regw      = 1'b1;
      end
      S_MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      S_EXECR: begin
        c.alusrcb = SRCB_RD2;
        c.aluop   = 1'b1;
      end
      S_EXECI: begin
        c.alusrcb = SRCB_IMM;
        c.aluop   = 1'b1;
      end
      S_ALUWB:  c.regw = 1'b1;
      S_BRANCH: begin
        c.alusrcb   = SRCB_IMM;
        c.resultsrc = RES_ALU;
        c.branch    = 1'b1;
      end
      default: ;
    endcase
    // FETCH enables must not fire during reset.
    if (!reset) begin
      c.irwrite = 1'b0;
      c.nextpc  = 1'b0;
    end
  end

  assign nextpc    = c.nextpc;
  assign branch    = c.branch;
  assign regw      = c.regw;
  assign memw      = c.memw;
  assign irwrite   = c.irwrite;
  assign adrsrc    = c.adrsrc;
  assign aluop     = c.aluop;
  assign decode    = c.decode;
  assign resultsrc = c.resultsrc;
  assign alusrca   = c.alusrca;
  assign alusrcb   = c.alusrcb;

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle controller for the ARM-subset processor.
//   clk, reset (sync, active low)
//   Cond/Op/Funct/Rd : instruction register fields
//   ALUFlags         : {N,Z,C,V} from the ALU this cycle (only feeds the flag reg)
//   PCWrite, IRWrite, MemWrite, RegWrite : condition-gated enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl : selects
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl
);

  logic       nextpc, branch, regw, memw, aluop, decode;
  logic       legal, condex, pcs;
  logic [1:0] flagw;
  logic [3:0] flags;

  mc_control_mainfsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .op        (Op),
    .funct     (Funct),
    .nextpc    (nextpc),
    .branch    (branch),
    .regw      (regw),
    .memw      (memw),
    .irwrite   (IRWrite),
    .adrsrc    (AdrSrc),
    .aluop     (aluop),
    .decode    (decode),
    .resultsrc (ResultSrc),
    .alusrca   (ALUSrcA),
    .alusrcb   (ALUSrcB)
  );

  // ALU decode; unknown commands fall back to add and never touch the flags.
  always_comb begin
    ALUControl = ALU_ADD;
    legal      = 1'b0;
    flagw      = 2'b00;
    if (aluop) begin
      legal = 1'b1;
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_TST: ALUControl = ALU_TST;
        CMD_TEQ: ALUControl = ALU_TEQ;
        CMD_CMP: ALUControl = ALU_CMP;
        default: begin
          ALUControl = ALU_ADD;
          legal      = 1'b0;
        end
      endcase
      flagw[1] = Funct[0] & legal & ~ALUControl[2];
      flagw[0] = Funct[0] & legal & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
    end
  end

  // CondEx is captured once per instruction at the end of DECODE so the
  // later gates cannot see flags written by this same instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      if (decode)            condex      <= cond_check(Cond, flags);
      if (flagw[1] & condex) flags[3:2]  <= ALUFlags[3:2];
      if (flagw[0] & condex) flags[1:0]  <= ALUFlags[1:0];
    end
  end

  assign pcs      = ((Rd == 4'b1111) & regw) | branch;
  assign RegWrite = regw & condex;
  assign MemWrite = memw & condex;
  assign PCWrite  = nextpc | (pcs & condex);
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == OP_BR, Op == OP_MEM};

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table vectors, directed sequences and random instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags, ALUControl;
  logic [1:0] Op, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  typedef struct packed {
    logic       pcw, irw, memw, regw, adr;
    logic [1:0] rs, sa, sb, imm, rsrc;
    logic [3:0] aluc;
  } out_t;

  typedef struct {
    logic [5:0] funct;
    logic [3:0] aluc;
  } vec_t;

  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4,
                 ST_MWR = 5, ST_ER = 6, ST_EI = 7, ST_AW = 8, ST_BR = 9;

  out_t       act;
  out_t       last_obs [5];
  logic [3:0] exec_aluc;
  logic [3:0] mflags;
  logic       mce;
  int         nvec, nbad;

  assign act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Condition test: even codes test a predicate, odd codes its negation.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  // {legal, ALUControl} per data-processing command.
  function automatic logic [4:0] alu_ref(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 5'b1_0000;
      4'b0010: return 5'b1_0001;
      4'b0000: return 5'b1_0010;
      4'b1100: return 5'b1_0011;
      4'b1000: return 5'b1_0111;
      4'b1001: return 5'b1_0110;
      4'b1010: return 5'b1_0100;
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic out_t exp_out(input int s, input logic [1:0] o, input logic [3:0] r,
                                   input logic ce, input logic [3:0] ac);
    out_t e;
    e      = '0;
    e.imm  = o;
    e.rsrc = {o == 2'b10, o == 2'b01};
    case (s)
      ST_F:   begin e.pcw = 1; e.irw = 1; e.rs = 2'b10; e.sa = 2'b01; e.sb = 2'b10; end
      ST_D:   begin e.rs = 2'b10; e.sa = 2'b01; e.sb = 2'b10; end
      ST_MA:  e.sb = 2'b01;
      ST_MR:  e.adr = 1;
      ST_MWB: begin e.rs = 2'b01; e.regw = ce; e.pcw = ce && (r == 4'hF); end
      ST_MWR: begin e.adr = 1; e.memw = ce; end
      ST_ER:  e.aluc = ac;
      ST_EI:  begin e.sb = 2'b01; e.aluc = ac; end
      ST_AW:  begin e.regw = ce; e.pcw = ce && (r == 4'hF); end
      ST_BR:  begin e.sb = 2'b01; e.rs = 2'b10; e.pcw = ce; end
      default: ;
    endcase
    return e;
  endfunction

  // One instruction from FETCH; af_fix>=0 pins ALUFlags in the execute
  // cycle, abort_at>=0 pulls reset during that step instead.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input int af_fix, input int abort_at);
    int         st[$];
    logic [4:0] ar;
    out_t       e;
    bit         ex;
    st = {ST_F, ST_D};
    case (o)
      2'b00: begin st.push_back(f[5] ? ST_EI : ST_ER); st.push_back(ST_AW); end
      2'b01: begin
        st.push_back(ST_MA);
        if (f[0]) begin st.push_back(ST_MR); st.push_back(ST_MWB); end
        else      st.push_back(ST_MWR);
      end
      2'b10: st.push_back(ST_BR);
      default: ;
    endcase
    Cond = c; Op = o; Funct = f; Rd = r;
    ar = alu_ref(f[4:1]);
    for (int i = 0; i < st.size(); i++) begin
      ex = (st[i] == ST_ER) || (st[i] == ST_EI);
      ALUFlags = (ex && af_fix >= 0) ? 4'(af_fix) : 4'($urandom);
      if (i == abort_at) begin
        reset = 1'b0;
        e = exp_out(ST_F, o, r, 1'b0, 4'h0);
        e.pcw = 0; e.irw = 0;
        @(negedge clk);
        check("reset_abort", 32'(act), 32'(e));
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mflags = 4'h0;
        mce    = 1'b0;
        return;
      end
      e = exp_out(st[i], o, r, mce, ar[3:0]);
      @(negedge clk);
      check($sformatf("op%0d_step%0d", o, i), 32'(act), 32'(e));
      if (i < 5) last_obs[i] = act;
      if (ex) exec_aluc = ALUControl;
      @(posedge clk);
      if (st[i] == ST_D) mce = cond_ok(c, mflags);
      if (ex && mce && f[0] && ar[4]) begin
        if (!ar[2])         mflags[3:2] = ALUFlags[3:2];
        if (ar[3:1] == 3'd0) mflags[1:0] = ALUFlags[1:0];
      end
      #1;
    end
  endtask

  initial begin
    vec_t       tbl [8];
    logic [3:0] legal_cmd [7];
    out_t       e;
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    int         ab;

    tbl[0] = '{6'b001001, 4'b0000};  // ADDS
    tbl[1] = '{6'b000101, 4'b0001};  // SUBS
    tbl[2] = '{6'b000000, 4'b0010};  // AND
    tbl[3] = '{6'b111001, 4'b0011};  // ORRS imm
    tbl[4] = '{6'b010001, 4'b0111};  // TST
    tbl[5] = '{6'b010011, 4'b0110};  // TEQ
    tbl[6] = '{6'b110101, 4'b0100};  // CMP imm
    tbl[7] = '{6'b011111, 4'b0000};  // unknown cmd
    legal_cmd = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1000, 4'b1001, 4'b1010};

    nvec = 0; nbad = 0; mflags = 4'h0; mce = 1'b0; exec_aluc = 4'h0;
    reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;

    // Reset held for three cycles: enables off, FETCH selects.
    for (int i = 0; i < 3; i++) begin
      e = exp_out(ST_F, 2'b00, 4'h0, 1'b0, 4'h0);
      e.pcw = 0; e.irw = 0;
      @(negedge clk);
      check("reset_hold", 32'(act), 32'(e));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;

    // ADDS R1,R2,R3 with ALUFlags=0100 -> flags 0100.
    run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4, -1);
    check("first_fetch_pcw_irw", 32'({last_obs[0].pcw, last_obs[0].irw}), 32'(2'b11));
    check("adds_aluc", 32'(exec_aluc), 32'(4'b0000));
    check("adds_regw_only_aluwb", 32'({last_obs[0].regw, last_obs[1].regw, last_obs[2].regw,
          last_obs[3].regw}), 32'(4'b0001));
    // BEQ with Z=1 taken, then clear Z and BEQ not taken.
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, -1, -1);
    check("beq_taken", 32'(last_obs[2].pcw), 32'(1'b1));
    run_instr(4'hE, 2'b00, 6'b001001, 4'd2, 0, -1);
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, -1, -1);
    check("beq_not_taken", 32'(last_obs[2].pcw), 32'(1'b0));
    // LDR
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, -1, -1);
    check("ldr_memrd_adr", 32'(last_obs[3].adr), 32'(1'b1));
    check("ldr_memwb", 32'({last_obs[4].rs, last_obs[4].regw}), 32'(3'b011));
    // STR with EQ and Z=0 suppressed; flags left alone so BNE still taken.
    run_instr(4'h0, 2'b01, 6'b011000, 4'd4, -1, -1);
    check("str_eq_suppressed", 32'(last_obs[3].memw), 32'(1'b0));
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4, -1, -1);
    check("str_al_memw", 32'(last_obs[3].memw), 32'(1'b1));
    run_instr(4'h1, 2'b10, 6'b100000, 4'd0, -1, -1);
    check("bne_after_str", 32'(last_obs[2].pcw), 32'(1'b1));
    // Data-processing into R15 writes the PC in ALUWB.
    run_instr(4'hE, 2'b00, 6'b101000, 4'hF, -1, -1);
    check("dp_pc_write", 32'({last_obs[3].pcw, last_obs[3].regw}), 32'(2'b11));
    // Op=11 no-op, then reset during MEMWB, then a normal instruction.
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, -1, -1);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd5, -1, 4);
    run_instr(4'hE, 2'b00, 6'b001000, 4'd6, -1, -1);
    // Flags cleared by that reset: EQ now fails.
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, -1, -1);
    check("beq_after_reset", 32'(last_obs[2].pcw), 32'(1'b0));

    // ALU decode table.
    for (int k = 0; k < 8; k++) begin
      run_instr(4'hE, 2'b00, tbl[k].funct, 4'($urandom_range(0, 14)), -1, -1);
      check($sformatf("alu_tbl%0d", k), 32'(exec_aluc), 32'(tbl[k].aluc));
    end

    // Random instruction stream with occasional mid-instruction reset.
    for (int k = 0; k < 250; k++) begin
      c = 4'($urandom); o = 2'($urandom); f = 6'($urandom); r = 4'($urandom);
      if (o == 2'b00 && $urandom_range(0, 3) != 0) f[4:1] = legal_cmd[$urandom_range(0, 6)];
      ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(c, o, f, r, -1, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle controller for the ARM-subset processor. It replaces the single-cycle decoder with a Moore state machine that sequences the shared datapath (one memory, one ALU, PC/IR/data registers) over 3–5 cycles per instruction. It also holds the NZCV condition flags and evaluates the condition field. It sits between the instruction register and every datapath mux select and write enable.

## Interface
Parameters:
- none; encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (L for memory ops)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  0=PC, 1=ALU result register
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result (direct)
- ALUSrcA  out  2  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  Op (00 data-proc, 01 memory, 10 branch)
- RegSrc  out  2  {Op==10, Op==01}
- ALUControl  out  4  ALU operation code

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - Op=01→MEMADR.
    - Op=00 with Funct[5]=0→EXECR.
    - Op=00 with Funct[5]=1→EXECI.
    - Op=10→BRANCH.
    - Op=11→FETCH (no-op).
  - MEMADR: Funct[0]=1→MEMRD, 0→MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BRANCH→FETCH.
- Per-state outputs (unlisted enables are 0; unlisted selects are 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add.
  - MEMADR: ALUSrcB=01, ALU add.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, ALU add, Branch=1.
- ALUOp=1 mapping of Funct[4:1] to ALUControl:
  - 0100→0000
  - 0010→0001
  - 0000→0010
  - 1100→0011
  - 1000→0111
  - 1001→0110
  - 1010→0100
  - any other cmd→0000, with no flag write.
- ALUOp=0 gives ALUControl=0000 (add).
- FlagW, only when ALUOp=1:
  - FlagW[1] = S & ~ALUControl[2].
  - FlagW[0] = S & (ALUControl ∈ {0000,0001}).
- Flags register, 4 bits NZCV:
  - [3:2] loaded from ALUFlags at the end of EXECR/EXECI when FlagW[1] & CondEx.
  - [1:0] loaded likewise when FlagW[0] & CondEx.
- CondEx is the full ARM condition decode (EQ…AL, 1111 treated as 0) of Cond against the stored flags. It is evaluated in DECODE and latched at the end of DECODE; every gate below uses the latched copy.
- Gated outputs:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCS = (Rd==1111 & RegW) | Branch.
  - PCWrite = NextPC | (PCS & CondEx).
- A failed condition still walks the full state path, with no architectural writes.

## Timing
- Reset: when reset=0 at a clk edge, the next state is FETCH, flags=0000, and latched CondEx=0.
- While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced 0; the selects show their FETCH values.
- First fetch happens in the first cycle after reset goes high.
- Mid-instruction reset abandons the instruction; no write occurs in the reset cycle.
- Cycles per instruction: data-processing 4, LDR 5, STR 4, B 3, Op=11 2.
- Outputs are Moore (state, plus latched CondEx and registered Instr fields); no combinational path from ALUFlags to any output.
- Flags written at the end of EXECR/EXECI are visible to the next instruction's DECODE.

## Structure
- Shared package holds:
  - state enum;
  - ALUControl codes;
  - ResultSrc, ALUSrcB and ImmSrc encodings;
  - ARM condition-code constants.
- Sub-module mainfsm holds the state register, next-state logic and raw per-state controls (RegW, MemW, NextPC, Branch, ALUOp, selects).
- Top level mc_control holds:
  - ALU decode and FlagW;
  - condition check;
  - flag and CondEx registers;
  - output gating.

## Test plan
- Reset held low 3 cycles, then released → all enables 0 during reset; cycle 1 after release is FETCH with IRWrite=1, PCWrite=1; cycle 2 is DECODE.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001) with ALUFlags=0100 in EXECR → ALUControl=0000; flags=0100 after EXECR; RegWrite=1 only in ALUWB; 4 cycles total.
- LDR (Op=01, Funct[0]=1) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB.
- BEQ with Z=1, then BEQ with Z=0 → first pulses PCWrite in BRANCH; second leaves PCWrite=0 in BRANCH; both take 3 cycles.
- STR with Cond=0000 and Z=0 → MemWrite stays 0 in MEMWR; flags unchanged; returns to FETCH.
- Reset asserted during MEMWB → no RegWrite on that edge; FETCH follows release.
